// File: rtl/mcpu_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset controller.
// Covers state codes, opcode/funct constants, ALU codes and datapath mux encodings.
package mcpu_pkg;

    typedef enum logic [4:0] {
        S_IF    = 5'd0,
        S_ID    = 5'd1,
        S_MADDR = 5'd2,
        S_MRD   = 5'd3,
        S_LWB   = 5'd4,
        S_MWR   = 5'd5,
        S_REX   = 5'd6,
        S_RWB   = 5'd7,
        S_BR    = 5'd8,
        S_JMP   = 5'd9,
        S_IEX   = 5'd10,
        S_IWB   = 5'd11,
        S_JAL   = 5'd12,
        S_INTE  = 5'd13,
        S_ERET  = 5'd14,
        S_RST   = 5'd31
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A, OP_ANDI = 6'h0C, OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_COP0  = 6'h10, OP_LW   = 6'h23, OP_SW   = 6'h2B;

    localparam logic [5:0] FN_SRL = 6'h02, FN_ERET = 6'h18, FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22, FN_AND  = 6'h24, FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26, FN_NOR  = 6'h27, FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_AND = 3'b000, ALU_OR  = 3'b001, ALU_ADD = 3'b010, ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_NOR = 3'b100, ALU_SRL = 3'b101, ALU_SUB = 3'b110, ALU_SLT = 3'b111;

    // PC_EXC picks int_vec while EPCWrite is high and the saved EPC otherwise.
    localparam logic [1:0] PC_ALU  = 2'b00, PC_ALUOUT = 2'b01, PC_JUMP  = 2'b10, PC_EXC  = 2'b11;
    localparam logic [1:0] RD_RT   = 2'b00, RD_RD     = 2'b01, RD_RA    = 2'b10;
    localparam logic [1:0] WB_ALU  = 2'b00, WB_MEM    = 2'b01, WB_PC    = 2'b10;
    localparam logic [1:0] SRCB_RT = 2'b00, SRCB_FOUR = 2'b01, SRCB_IMM = 2'b10, SRCB_BOFF = 2'b11;

    typedef struct packed {
        logic       memRead;
        logic       memWrite;
        logic       cpuMio;
        logic       iorD;
        logic       irWrite;
        logic       regWrite;
        logic       aluSrcA;
        logic       pcWrite;
        logic       pcWriteCond;
        logic       branch;
        logic       epcWrite;
        logic       intAck;
        logic [1:0] regDst;
        logic [1:0] memtoReg;
        logic [1:0] aluSrcB;
        logic [1:0] pcSource;
        logic [2:0] aluOp;
    } ctrl_t;

    function automatic logic [2:0] functToAlu(input logic [5:0] funct);
        case (funct)
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_XOR:  return ALU_XOR;
            FN_NOR:  return ALU_NOR;
            FN_SLT:  return ALU_SLT;
            FN_SRL:  return ALU_SRL;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic logic [2:0] immToAlu(input logic [5:0] opcode);
        case (opcode)
            OP_SLTI: return ALU_SLT;
            OP_ANDI: return ALU_AND;
            OP_ORI:  return ALU_OR;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mcpu_ctrl_irq_if.sv
// Controller-to-datapath bundle.
// The master side is the control unit; the slave side is the datapath/CPU top.
interface mcpu_ctrl_irq_if #(
    parameter int unsigned NINT   = 4,
    parameter int unsigned ADDR_W = 32
);
    logic              zero;
    logic              overflow;
    logic              MIO_ready;
    logic [31:0]       Inst_in;
    logic [NINT-1:0]   INT;

    logic              MemRead, MemWrite, CPU_MIO, IorD, IRWrite, RegWrite;
    logic              ALUSrcA, PCWrite, PCWriteCond, Branch;
    logic [1:0]        RegDst, MemtoReg, ALUSrcB, PCSource;
    logic [2:0]        ALU_operation;
    logic              EPCWrite;
    logic [ADDR_W-1:0] int_vec;
    logic              IntAck;
    logic [2:0]        IntId;
    logic [4:0]        state_out;

    modport master (
        input  zero, overflow, MIO_ready, Inst_in, INT,
        output MemRead, MemWrite, CPU_MIO, IorD, IRWrite, RegWrite, ALUSrcA, PCWrite,
               PCWriteCond, Branch, RegDst, MemtoReg, ALUSrcB, PCSource, ALU_operation,
               EPCWrite, int_vec, IntAck, IntId, state_out
    );

    modport slave (
        output zero, overflow, MIO_ready, Inst_in, INT,
        input  MemRead, MemWrite, CPU_MIO, IorD, IRWrite, RegWrite, ALUSrcA, PCWrite,
               PCWriteCond, Branch, RegDst, MemtoReg, ALUSrcB, PCSource, ALU_operation,
               EPCWrite, int_vec, IntAck, IntId, state_out
    );

endinterface

// File: rtl/mcpu_irq_prio.sv
// Interrupt priority encoder (lowest set line wins) and vector address generator.
// The vector is formed from the id the parent latched when it took the interrupt.
module mcpu_irq_prio #(
    parameter int unsigned       NINT       = 4,
    parameter int unsigned       ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] VEC_BASE   = 32'h0000_0100,
    parameter int unsigned       VEC_STRIDE = 8
) (
    input  logic [NINT-1:0]   req_i,
    input  logic [2:0]        heldId_i,
    output logic              anyReq_o,
    output logic [2:0]        reqId_o,
    output logic [ADDR_W-1:0] vec_o
);

    // Scanning from the top down leaves the lowest set line as the final winner.
    always_comb begin
        anyReq_o = 1'b0;
        reqId_o  = 3'd0;
        for (int i = int'(NINT) - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                anyReq_o = 1'b1;
                reqId_o  = 3'(i);
            end
        end
    end

    assign vec_o = VEC_BASE + ADDR_W'(VEC_STRIDE) * ADDR_W'(heldId_i);

endmodule

// File: rtl/mcpu_ctrl_irq.sv
// Multi-cycle control unit with memory wait states, vectored interrupts and ERET.
// Outputs are Moore-decoded from the state, except IRWrite/PCWrite in IF which wait for MIO_ready.
module mcpu_ctrl_irq
    import mcpu_pkg::*;
#(
    parameter int unsigned       NINT       = 4,
    parameter int unsigned       ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] VEC_BASE   = 32'h0000_0100,
    parameter int unsigned       VEC_STRIDE = 8,
    parameter bit                IE_RESET   = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    mcpu_ctrl_irq_if.master bus
);

    state_e            state_q, state_d;
    logic              ie_q, ie_d;
    logic [2:0]        intId_q, intId_d;
    logic              anyReq, retire;
    logic [2:0]        reqId;
    logic [ADDR_W-1:0] vecAddr;
    ctrl_t             ctrl;
    logic [5:0]        opcode, funct;
    logic              unusedInputs;

    assign opcode       = bus.Inst_in[31:26];
    assign funct        = bus.Inst_in[5:0];
    assign unusedInputs = ^{bus.zero, bus.overflow, bus.Inst_in[25:6]};

    mcpu_irq_prio #(
        .NINT      (NINT),
        .ADDR_W    (ADDR_W),
        .VEC_BASE  (VEC_BASE),
        .VEC_STRIDE(VEC_STRIDE)
    ) uPrio (
        .req_i   (bus.INT),
        .heldId_i(intId_q),
        .anyReq_o(anyReq),
        .reqId_o (reqId),
        .vec_o   (vecAddr)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_RST;
            ie_q    <= IE_RESET;
            intId_q <= 3'd0;
        end else begin
            state_q <= state_d;
            ie_q    <= ie_d;
            intId_q <= intId_d;
        end
    end

    // Every instruction-completing path funnels through retire, the only point interrupts are sampled.
    always_comb begin
        state_d = state_q;
        ie_d    = ie_q;
        intId_d = intId_q;
        retire  = 1'b0;
        case (state_q)
            S_RST:   state_d = S_IF;
            S_IF:    if (bus.MIO_ready) state_d = S_ID;
            S_ID: begin
                case (opcode)
                    OP_RTYPE:                         state_d = S_REX;
                    OP_LW, OP_SW:                     state_d = S_MADDR;
                    OP_BEQ, OP_BNE:                   state_d = S_BR;
                    OP_J:                             state_d = S_JMP;
                    OP_JAL:                           state_d = S_JAL;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_d = S_IEX;
                    OP_COP0: begin
                        if (funct == FN_ERET) state_d = S_ERET;
                        else                  retire  = 1'b1;
                    end
                    default:                          retire  = 1'b1;
                endcase
            end
            S_MADDR: state_d = (opcode == OP_LW) ? S_MRD : S_MWR;
            S_MRD:   if (bus.MIO_ready) state_d = S_LWB;
            S_MWR:   if (bus.MIO_ready) retire  = 1'b1;
            S_REX:   state_d = S_RWB;
            S_IEX:   state_d = S_IWB;
            S_LWB, S_RWB, S_BR, S_JMP, S_IWB, S_JAL: retire = 1'b1;
            S_INTE: begin
                state_d = S_IF;
                ie_d    = 1'b0;
            end
            S_ERET: begin
                state_d = S_IF;
                ie_d    = 1'b1;
            end
            default: state_d = S_IF;
        endcase
        if (retire) begin
            if (ie_q && anyReq) begin
                state_d = S_INTE;
                intId_d = reqId;
            end else begin
                state_d = S_IF;
            end
        end
    end

    always_comb begin
        ctrl = '0;
        case (state_q)
            S_IF: begin
                ctrl.memRead = 1'b1;
                ctrl.cpuMio  = 1'b1;
                ctrl.aluSrcB = SRCB_FOUR;
                ctrl.aluOp   = ALU_ADD;
                ctrl.irWrite = bus.MIO_ready;
                ctrl.pcWrite = bus.MIO_ready;
            end
            S_ID: begin
                ctrl.aluSrcB = SRCB_BOFF;
                ctrl.aluOp   = ALU_ADD;
            end
            S_MADDR: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SRCB_IMM;
                ctrl.aluOp   = ALU_ADD;
            end
            S_MRD: begin
                ctrl.memRead = 1'b1;
                ctrl.cpuMio  = 1'b1;
                ctrl.iorD    = 1'b1;
            end
            S_MWR: begin
                ctrl.memWrite = 1'b1;
                ctrl.cpuMio   = 1'b1;
                ctrl.iorD     = 1'b1;
            end
            S_LWB: begin
                ctrl.regWrite = 1'b1;
                ctrl.regDst   = RD_RT;
                ctrl.memtoReg = WB_MEM;
            end
            S_REX: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SRCB_RT;
                ctrl.aluOp   = functToAlu(funct);
            end
            S_RWB: begin
                ctrl.regWrite = 1'b1;
                ctrl.regDst   = RD_RD;
                ctrl.memtoReg = WB_ALU;
            end
            S_BR: begin
                ctrl.aluSrcA     = 1'b1;
                ctrl.aluSrcB     = SRCB_RT;
                ctrl.aluOp       = ALU_SUB;
                ctrl.pcWriteCond = 1'b1;
                ctrl.pcSource    = PC_ALUOUT;
                ctrl.branch      = (opcode == OP_BNE);
            end
            S_JMP: begin
                ctrl.pcWrite  = 1'b1;
                ctrl.pcSource = PC_JUMP;
            end
            S_JAL: begin
                ctrl.pcWrite  = 1'b1;
                ctrl.pcSource = PC_JUMP;
                ctrl.regWrite = 1'b1;
                ctrl.regDst   = RD_RA;
                ctrl.memtoReg = WB_PC;
            end
            S_IEX: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SRCB_IMM;
                ctrl.aluOp   = immToAlu(opcode);
            end
            S_IWB: begin
                ctrl.regWrite = 1'b1;
                ctrl.regDst   = RD_RT;
                ctrl.memtoReg = WB_ALU;
            end
            S_INTE: begin
                ctrl.epcWrite = 1'b1;
                ctrl.pcWrite  = 1'b1;
                ctrl.pcSource = PC_EXC;
                ctrl.intAck   = 1'b1;
            end
            S_ERET: begin
                ctrl.pcWrite  = 1'b1;
                ctrl.pcSource = PC_EXC;
            end
            default: ;
        endcase
    end

    assign bus.MemRead       = ctrl.memRead;
    assign bus.MemWrite      = ctrl.memWrite;
    assign bus.CPU_MIO       = ctrl.cpuMio;
    assign bus.IorD          = ctrl.iorD;
    assign bus.IRWrite       = ctrl.irWrite;
    assign bus.RegWrite      = ctrl.regWrite;
    assign bus.ALUSrcA       = ctrl.aluSrcA;
    assign bus.PCWrite       = ctrl.pcWrite;
    assign bus.PCWriteCond   = ctrl.pcWriteCond;
    assign bus.Branch        = ctrl.branch;
    assign bus.RegDst        = ctrl.regDst;
    assign bus.MemtoReg      = ctrl.memtoReg;
    assign bus.ALUSrcB       = ctrl.aluSrcB;
    assign bus.PCSource      = ctrl.pcSource;
    assign bus.ALU_operation = ctrl.aluOp;
    assign bus.EPCWrite      = ctrl.epcWrite;
    assign bus.IntAck        = ctrl.intAck;
    assign bus.IntId         = ctrl.intAck ? intId_q : 3'd0;
    assign bus.int_vec       = (state_q == S_RST) ? '0 : vecAddr;
    assign bus.state_out     = state_q;

endmodule

// File: tb/tb_mcpu_ctrl_irq.sv
// Directed bench for mcpu_ctrl_irq: a per-cycle vector table for the instruction flows,
// then hand-written sequences for interrupt entry/return, stalls and asynchronous reset.
module tb_mcpu_ctrl_irq;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mcpu_ctrl_irq_if #(.NINT(4), .ADDR_W(32)) bus ();

    mcpu_ctrl_irq #(
        .NINT      (4),
        .ADDR_W    (32),
        .VEC_BASE  (32'h0000_0100),
        .VEC_STRIDE(8),
        .IE_RESET  (1'b1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // {flags9, alu3, pcSource2, {ALUSrcA,ALUSrcB}3, {RegDst,MemtoReg}4, {CPU_MIO,IorD}2}
    // flags9 = {MemRead, MemWrite, RegWrite, PCWrite, PCWriteCond, Branch, IRWrite, EPCWrite, IntAck}
    localparam logic [22:0] C_IF1   = {9'b100100100, 3'b010, 2'b00, 3'b001, 4'b0000, 2'b10};
    localparam logic [22:0] C_IF0   = {9'b100000000, 3'b010, 2'b00, 3'b001, 4'b0000, 2'b10};
    localparam logic [22:0] C_ID    = {9'b000000000, 3'b010, 2'b00, 3'b011, 4'b0000, 2'b00};
    localparam logic [22:0] C_MADDR = {9'b000000000, 3'b010, 2'b00, 3'b110, 4'b0000, 2'b00};
    localparam logic [22:0] C_MRD   = {9'b100000000, 3'b000, 2'b00, 3'b000, 4'b0000, 2'b11};
    localparam logic [22:0] C_MWR   = {9'b010000000, 3'b000, 2'b00, 3'b000, 4'b0000, 2'b11};
    localparam logic [22:0] C_LWB   = {9'b001000000, 3'b000, 2'b00, 3'b000, 4'b0001, 2'b00};
    localparam logic [22:0] C_RWB   = {9'b001000000, 3'b000, 2'b00, 3'b000, 4'b0100, 2'b00};
    localparam logic [22:0] C_BEQ   = {9'b000010000, 3'b110, 2'b01, 3'b100, 4'b0000, 2'b00};
    localparam logic [22:0] C_BNE   = {9'b000011000, 3'b110, 2'b01, 3'b100, 4'b0000, 2'b00};
    localparam logic [22:0] C_JMP   = {9'b000100000, 3'b000, 2'b10, 3'b000, 4'b0000, 2'b00};
    localparam logic [22:0] C_JAL   = {9'b001100000, 3'b000, 2'b10, 3'b000, 4'b1010, 2'b00};
    localparam logic [22:0] C_IWB   = {9'b001000000, 3'b000, 2'b00, 3'b000, 4'b0000, 2'b00};
    localparam logic [22:0] C_INTE  = {9'b000100011, 3'b000, 2'b11, 3'b000, 4'b0000, 2'b00};
    localparam logic [22:0] C_ERET  = {9'b000100000, 3'b000, 2'b11, 3'b000, 4'b0000, 2'b00};

    localparam logic [31:0] I_LW   = 32'h8C00_0000, I_SW   = 32'hAC00_0000;
    localparam logic [31:0] I_ADD  = 32'h0000_0020, I_SUB  = 32'h0000_0022;
    localparam logic [31:0] I_SRL  = 32'h0000_0002, I_NOR  = 32'h0000_0027;
    localparam logic [31:0] I_AND  = 32'h0000_0024, I_RBAD = 32'h0000_003F;
    localparam logic [31:0] I_BEQ  = 32'h1000_0000, I_BNE  = 32'h1400_0000;
    localparam logic [31:0] I_J    = 32'h0800_0000, I_JAL  = 32'h0C00_0000;
    localparam logic [31:0] I_SLTI = 32'h2800_0000, I_ORI  = 32'h3400_0000;
    localparam logic [31:0] I_ANDI = 32'h3000_0000, I_ILL  = 32'hFC00_0000;
    localparam logic [31:0] I_C0   = 32'h4000_0000, I_ERET = 32'h4200_0018;

    typedef struct {
        logic [31:0] inst;
        logic        mio;
        logic        zero;
        logic [3:0]  intr;
        logic [4:0]  expState;
        logic [22:0] expCtrl;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [22:0] rexC(input logic [2:0] alu);
        return {9'b0, alu, 2'b00, 3'b100, 4'b0000, 2'b00};
    endfunction

    function automatic logic [22:0] iexC(input logic [2:0] alu);
        return {9'b0, alu, 2'b00, 3'b110, 4'b0000, 2'b00};
    endfunction

    function automatic logic [22:0] ctrlNow();
        return {bus.MemRead, bus.MemWrite, bus.RegWrite, bus.PCWrite, bus.PCWriteCond,
                bus.Branch, bus.IRWrite, bus.EPCWrite, bus.IntAck, bus.ALU_operation,
                bus.PCSource, bus.ALUSrcA, bus.ALUSrcB, bus.RegDst, bus.MemtoReg,
                bus.CPU_MIO, bus.IorD};
    endfunction

    task automatic addRow(input logic [31:0] inst, input logic mio, input logic zero,
                          input logic [4:0] st, input logic [22:0] c);
        vecs.push_back('{inst, mio, zero, 4'b0000, st, c});
    endtask

    task automatic applyStimulus(input logic [31:0] inst, input logic mio, input logic zero,
                                 input logic [3:0] intr);
        bus.Inst_in   = inst;
        bus.MIO_ready = mio;
        bus.zero      = zero;
        bus.INT       = intr;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Adds one instruction that passes IF and ID without stalls.
    task automatic addFetch(input logic [31:0] inst, input logic zero);
        addRow(inst, 1'b1, zero, 5'd0, C_IF1);
        addRow(inst, 1'b1, zero, 5'd1, C_ID);
    endtask

    initial begin
        bus.overflow = 1'b0;
        applyStimulus(32'h0, 1'b1, 1'b0, 4'b0000);
        reset = 1'b0;

        // lw with two IF waits and three MRD waits
        addRow(I_LW, 1'b0, 1'b0, 5'd0, C_IF0);
        addRow(I_LW, 1'b0, 1'b0, 5'd0, C_IF0);
        addRow(I_LW, 1'b1, 1'b0, 5'd0, C_IF1);
        addRow(I_LW, 1'b1, 1'b0, 5'd1, C_ID);
        addRow(I_LW, 1'b0, 1'b0, 5'd2, C_MADDR);
        addRow(I_LW, 1'b0, 1'b0, 5'd3, C_MRD);
        addRow(I_LW, 1'b0, 1'b0, 5'd3, C_MRD);
        addRow(I_LW, 1'b0, 1'b0, 5'd3, C_MRD);
        addRow(I_LW, 1'b1, 1'b0, 5'd3, C_MRD);
        addRow(I_LW, 1'b1, 1'b0, 5'd4, C_LWB);
        addFetch(I_SW, 1'b0);
        addRow(I_SW, 1'b1, 1'b0, 5'd2, C_MADDR);
        addRow(I_SW, 1'b1, 1'b0, 5'd5, C_MWR);
        addFetch(I_ADD, 1'b0);
        addRow(I_ADD, 1'b1, 1'b0, 5'd6, rexC(3'b010));
        addRow(I_ADD, 1'b1, 1'b0, 5'd7, C_RWB);
        addFetch(I_SUB, 1'b0);
        addRow(I_SUB, 1'b1, 1'b0, 5'd6, rexC(3'b110));
        addRow(I_SUB, 1'b1, 1'b0, 5'd7, C_RWB);
        addFetch(I_SRL, 1'b0);
        addRow(I_SRL, 1'b1, 1'b0, 5'd6, rexC(3'b101));
        addRow(I_SRL, 1'b1, 1'b0, 5'd7, C_RWB);
        addFetch(I_NOR, 1'b0);
        addRow(I_NOR, 1'b1, 1'b0, 5'd6, rexC(3'b100));
        addRow(I_NOR, 1'b1, 1'b0, 5'd7, C_RWB);
        addFetch(I_AND, 1'b0);
        addRow(I_AND, 1'b1, 1'b0, 5'd6, rexC(3'b000));
        addRow(I_AND, 1'b1, 1'b0, 5'd7, C_RWB);
        addFetch(I_RBAD, 1'b0);
        addRow(I_RBAD, 1'b1, 1'b0, 5'd6, rexC(3'b010));
        addRow(I_RBAD, 1'b1, 1'b0, 5'd7, C_RWB);
        addFetch(I_BEQ, 1'b1);
        addRow(I_BEQ, 1'b1, 1'b1, 5'd8, C_BEQ);
        addFetch(I_BNE, 1'b1);
        addRow(I_BNE, 1'b1, 1'b1, 5'd8, C_BNE);
        addFetch(I_J, 1'b0);
        addRow(I_J, 1'b1, 1'b0, 5'd9, C_JMP);
        addFetch(I_JAL, 1'b0);
        addRow(I_JAL, 1'b1, 1'b0, 5'd12, C_JAL);
        addFetch(I_SLTI, 1'b0);
        addRow(I_SLTI, 1'b1, 1'b0, 5'd10, iexC(3'b111));
        addRow(I_SLTI, 1'b1, 1'b0, 5'd11, C_IWB);
        addFetch(I_ORI, 1'b0);
        addRow(I_ORI, 1'b1, 1'b0, 5'd10, iexC(3'b001));
        addRow(I_ORI, 1'b1, 1'b0, 5'd11, C_IWB);
        addFetch(I_ANDI, 1'b0);
        addRow(I_ANDI, 1'b1, 1'b0, 5'd10, iexC(3'b000));
        addRow(I_ANDI, 1'b1, 1'b0, 5'd11, C_IWB);
        addFetch(I_ILL, 1'b0);
        addFetch(I_C0, 1'b0);
        addRow(I_ILL, 1'b0, 1'b0, 5'd0, C_IF0);

        // Reset held for three cycles
        step();
        step();
        step();
        checkOutput("rst_state", 32'(bus.state_out), 32'd31);
        checkOutput("rst_ctrl", 32'(ctrlNow()), 32'd0);
        checkOutput("rst_vec", bus.int_vec, 32'd0);
        checkOutput("rst_id", 32'(bus.IntId), 32'd0);
        reset = 1'b1;
        step();
        checkOutput("rst_release", 32'(bus.state_out), 32'd0);

        foreach (vecs[k]) begin
            applyStimulus(vecs[k].inst, vecs[k].mio, vecs[k].zero, vecs[k].intr);
            #1;
            checkOutput($sformatf("row%0d_state", k), 32'(bus.state_out), 32'(vecs[k].expState));
            checkOutput($sformatf("row%0d_ctrl", k), 32'(ctrlNow()), 32'(vecs[k].expCtrl));
            step();
        end

        // Interrupt raised during add is taken after RWB
        applyStimulus(I_ADD, 1'b1, 1'b0, 4'b0110);
        step();
        step();
        step();
        checkOutput("irq_rwb", 32'(bus.state_out), 32'd7);
        step();
        checkOutput("irq_state", 32'(bus.state_out), 32'd13);
        checkOutput("irq_ctrl", 32'(ctrlNow()), 32'(C_INTE));
        checkOutput("irq_id", 32'(bus.IntId), 32'd1);
        checkOutput("irq_vec", bus.int_vec, 32'h108);
        step();
        checkOutput("irq_ack_pulse", 32'(bus.IntAck), 32'd0);
        step();
        step();
        step();
        step();
        checkOutput("irq_masked", 32'(bus.state_out), 32'd0);

        // ERET re-enables; the still-pending line is taken after the next instruction
        applyStimulus(I_ERET, 1'b1, 1'b0, 4'b0110);
        step();
        step();
        checkOutput("eret_state", 32'(bus.state_out), 32'd14);
        checkOutput("eret_ctrl", 32'(ctrlNow()), 32'(C_ERET));
        step();
        checkOutput("eret_to_if", 32'(bus.state_out), 32'd0);
        applyStimulus(I_J, 1'b1, 1'b0, 4'b0110);
        step();
        step();
        step();
        checkOutput("eret_pending", 32'(bus.state_out), 32'd13);
        checkOutput("eret_pending_id", 32'(bus.IntId), 32'd1);
        applyStimulus(I_ERET, 1'b1, 1'b0, 4'b0000);
        step();
        step();
        step();
        step();

        // Interrupt raised while sw stalls waits for the store to finish
        applyStimulus(I_SW, 1'b1, 1'b0, 4'b0000);
        step();
        step();
        step();
        applyStimulus(I_SW, 1'b0, 1'b0, 4'b0001);
        step();
        checkOutput("stall_hold1", 32'(bus.state_out), 32'd5);
        step();
        checkOutput("stall_hold2", 32'(bus.state_out), 32'd5);
        applyStimulus(I_SW, 1'b1, 1'b0, 4'b0001);
        step();
        checkOutput("stall_irq", 32'(bus.state_out), 32'd13);
        checkOutput("stall_vec", bus.int_vec, 32'h100);
        applyStimulus(I_SW, 1'b1, 1'b0, 4'b0000);
        step();

        // Asynchronous reset while a store is in progress
        step();
        step();
        applyStimulus(I_SW, 1'b0, 1'b0, 4'b0000);
        step();
        checkOutput("mwr_write", 32'(bus.MemWrite), 32'd1);
        #2 reset = 1'b0;
        #1;
        checkOutput("async_state", 32'(bus.state_out), 32'd31);
        checkOutput("async_memwrite", 32'(bus.MemWrite), 32'd0);
        step();
        step();
        reset = 1'b1;
        applyStimulus(I_ADD, 1'b1, 1'b0, 4'b0000);
        step();
        checkOutput("rerelease", 32'(bus.state_out), 32'd0);

        // A request withdrawn before the sampling edge is ignored
        step();
        step();
        applyStimulus(I_ADD, 1'b1, 1'b0, 4'b1000);
        step();
        applyStimulus(I_ADD, 1'b1, 1'b0, 4'b0000);
        step();
        checkOutput("withdrawn", 32'(bus.state_out), 32'd0);

        // Priority: lowest set line of 4'b1100 is line 2
        applyStimulus(I_J, 1'b1, 1'b0, 4'b1100);
        step();
        step();
        step();
        checkOutput("prio_state", 32'(bus.state_out), 32'd13);
        checkOutput("prio_id", 32'(bus.IntId), 32'd2);
        checkOutput("prio_vec", bus.int_vec, 32'h110);
        applyStimulus(I_J, 1'b1, 1'b0, 4'b0000);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mcpu_ctrl_irq.md
# mcpu_ctrl_irq

Parametrised multi-cycle control unit for the MIPS-subset multi-cycle CPU. It replaces the fixed controller with one that has three added behaviours: MIO_ready wait-state stalls on every memory state, NINT prioritised vectored interrupts with EPC save, and an ERET return path. It drives the existing multi-cycle datapath's control inputs and sits between the instruction register output and the datapath inside the CPU top.

## Interface
- NINT, 4: number of level-sensitive interrupt lines, 1..8
- ADDR_W, 32: PC/vector width
- VEC_BASE, 32'h0000_0100: vector of interrupt 0
- VEC_STRIDE, 8: byte distance between consecutive vectors
- IE_RESET, 1: interrupt-enable value after reset

- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- zero  input  1  ALU zero flag
- overflow  input  1  ALU overflow; ignored, no exception
- MIO_ready  input  1  memory access completes this cycle
- Inst_in  input  32  instruction register contents
- INT  input  NINT  interrupt requests, level, bit 0 highest priority
- MemRead, MemWrite, CPU_MIO, IorD, IRWrite, RegWrite, ALUSrcA, PCWrite, PCWriteCond, Branch  output  1 each  datapath controls (Branch=1 selects bne)
- RegDst, MemtoReg, ALUSrcB, PCSource  output  2 each  mux selects
- ALU_operation  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt, 100 nor, 011 xor, 101 srl
- EPCWrite  output  1  latch PC into EPC
- int_vec  output  ADDR_W  VEC_BASE + id*VEC_STRIDE
- IntAck  output  1  one-cycle pulse on interrupt entry
- IntId  output  3  acknowledged line, valid with IntAck
- state_out  output  5  current state code

## Operation
- States and codes: IF 0, ID 1, MADDR 2, MRD 3, LWB 4, MWR 5, REX 6, RWB 7, BR 8, JMP 9, IEX 10, IWB 11, JAL 12, INTE 13, ERET 14, RST 31.
- RST:
  - Entered asynchronously while reset=0.
  - All outputs 0, IntAck 0, ie=IE_RESET.
  - First clock after release goes to IF.
- IF:
  - Asserts MemRead, CPU_MIO, IorD=0, ALUSrcA=0, ALUSrcB=01, add, PCSource=00.
  - IRWrite and PCWrite are asserted only when MIO_ready=1; otherwise the state holds with all other outputs unchanged.
- ID:
  - ALUSrcA=0, ALUSrcB=11, add (branch target).
  - Decodes the opcode:
    - 0x00 → REX
    - 0x23/0x2B → MADDR
    - 0x04/0x05 → BR
    - 0x02 → JMP
    - 0x03 → JAL
    - 0x08/0x0A/0x0C/0x0D → IEX
    - 0x10 with funct 0x18 → ERET
    - any other opcode → IF (NOP)
- MADDR: ALUSrcA=1, ALUSrcB=10, add. Next state MRD (lw) or MWR (sw).
- MRD: MemRead, CPU_MIO, IorD=1. Stalls until MIO_ready, then LWB.
- MWR: MemWrite, CPU_MIO, IorD=1. Stalls until MIO_ready, then IF.
- LWB: RegWrite, RegDst=00, MemtoReg=01.
- REX: ALUSrcA=1, ALUSrcB=00, ALU code from funct:
  - 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x26 xor, 0x27 nor, 0x2A slt, 0x02 srl.
  - Any other funct: add.
- RWB: RegWrite, RegDst=01, MemtoReg=00.
- BR: ALUSrcA=1, ALUSrcB=00, sub, PCWriteCond, PCSource=01, Branch=1 for opcode 0x05.
- JMP: PCWrite, PCSource=10.
- JAL: PCWrite, PCSource=10, RegWrite, RegDst=10, MemtoReg=10.
- IEX: ALUSrcA=1, ALUSrcB=10. ALU code: addi→add, slti→slt, andi→and, ori→or.
- IWB: RegWrite, RegDst=00, MemtoReg=00.
- Interrupts:
  - Sampled only on a transition into IF from LWB, MWR, RWB, BR, JMP, IWB, JAL, or the ID NOP path.
  - If ie=1 and INT≠0, the next state is INTE instead of IF.
  - The lowest set bit wins; id is registered at that decision.
- INTE:
  - EPCWrite, PCWrite, PCSource=11, IntAck=1, IntId=id, ie←0.
  - Next state IF.
- ERET: PCWrite, PCSource=11, EPCWrite=0 (datapath selects EPC), ie←1. Next state IF.
- PCSource=11 selects int_vec when EPCWrite=1, otherwise EPC.

## Timing
- Outputs are Moore-decoded from state. The exceptions are IRWrite/PCWrite in IF, which are gated by MIO_ready.
- Zero-wait cycle counts: lw 5, sw 4, R 4, I-ALU 4, beq/bne 3, j 3, jal 3, ERET 3, NOP 2, interrupt entry 1 extra.
- Each MIO_ready=0 cycle in IF/MRD/MWR adds exactly one cycle. No timeout.
- INT asserted during a stall is not taken until the instruction completes.
- INT deasserted before the sampling edge is not taken.
- reset low mid-instruction: immediately RST, no partial register or memory write after the asynchronous edge.

## Structure
- Shared package mcpu_pkg: state codes, opcode/funct constants, ALU_operation codes, PCSource/RegDst/MemtoReg encodings.
- Sub-module mcpu_irq_prio: combinational NINT priority encoder plus int_vec computation, registered id held in the parent.

## Test plan
- Reset low for 3 cycles, release with MIO_ready=1 → state_out 31 then 0, all controls 0 during RST.
- lw with 2 wait cycles in IF and 3 in MRD → state sequence 0,0,0,1,2,3,3,3,3,4,0; RegWrite only in state 4.
- beq with zero=1, then bne with zero=1 → both PCWriteCond=1; Branch 0 then 1.
- INT=4'b0110 during add → after RWB the state is 13 with IntAck=1, IntId=1, int_vec=0x108. INT held high does not re-enter until ERET.
- ERET (0x42000018) → PCSource=11, EPCWrite=0, then IF. A pending INT is taken after the next completed instruction.
- Illegal opcode 0x3F → 1→0 with no RegWrite/MemWrite. reset asserted in MWR → MemWrite drops immediately.
